// File: rtl/reg_bank_write_arbiter_if.sv
// Request/ack handshakes from two writers and a clearer, plus the latch-bank drive lines.
// The arbiter owns the slave side, and the requesters and bank own the master side.
interface reg_bank_write_arbiter_if;
  logic       req_a;
  logic [1:0] addr_a;
  logic [7:0] data_a;
  logic       ack_a;
  logic       req_b;
  logic [1:0] addr_b;
  logic [7:0] data_b;
  logic       ack_b;
  logic       clr_req;
  logic       clr_ack;
  logic [3:0] le;
  logic [7:0] wd;
  logic       wrst;
  logic       busy;

  modport master (
    output req_a, addr_a, data_a, req_b, addr_b, data_b, clr_req,
    input  ack_a, ack_b, clr_ack, le, wd, wrst, busy
  );

  modport slave (
    input  req_a, addr_a, data_a, req_b, addr_b, data_b, clr_req,
    output ack_a, ack_b, clr_ack, le, wd, wrst, busy
  );
endinterface

// File: rtl/reg_bank_write_arbiter.sv
// Serialises A/B writes and bank clears onto a 4x8 latch bank; ack at cycle LOAD_CYCLES+3 after grant.
// Requests are level-held and wait while busy; clear beats writes, A/B alternate round-robin.
module reg_bank_write_arbiter #(
  parameter int LOAD_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  reg_bank_write_arbiter_if.slave bus
);

  localparam int CW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, HOLD, ACK} state_t;
  typedef enum logic [1:0] {TXN_A, TXN_B, TXN_CLR} txn_t;

  state_t        state;
  txn_t          txn;
  logic [1:0]    addr_q;
  logic [CW-1:0] cnt;
  logic          last_b;
  logic          grant_a;
  logic          grant_b;

  // A tie goes to whoever was not served last.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!bus.clr_req) begin
      if (bus.req_a && bus.req_b) begin
        grant_a = last_b;
        grant_b = !last_b;
      end else begin
        grant_a = bus.req_a;
        grant_b = bus.req_b;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      txn         <= TXN_A;
      addr_q      <= 2'd0;
      cnt         <= '0;
      last_b      <= 1'b1;
      bus.le      <= 4'd0;
      bus.wd      <= 8'd0;
      bus.wrst    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.ack_a   <= 1'b0;
      bus.ack_b   <= 1'b0;
      bus.clr_ack <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            txn      <= TXN_CLR;
            addr_q   <= 2'd0;
            bus.wd   <= 8'd0;
            bus.busy <= 1'b1;
            state    <= SETUP;
          end else if (grant_a) begin
            txn      <= TXN_A;
            addr_q   <= bus.addr_a;
            bus.wd   <= bus.data_a;
            bus.busy <= 1'b1;
            state    <= SETUP;
          end else if (grant_b) begin
            txn      <= TXN_B;
            addr_q   <= bus.addr_b;
            bus.wd   <= bus.data_b;
            bus.busy <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          cnt      <= CW'(LOAD_CYCLES - 1);
          bus.le   <= (txn == TXN_CLR) ? 4'b1111 : (4'b0001 << addr_q);
          bus.wrst <= (txn == TXN_CLR);
          state    <= LOAD;
        end
        LOAD: begin
          // wrst deliberately stays up through HOLD for hold time after le falls.
          if (cnt == '0) begin
            bus.le <= 4'd0;
            state  <= HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          bus.wrst    <= 1'b0;
          bus.ack_a   <= (txn == TXN_A);
          bus.ack_b   <= (txn == TXN_B);
          bus.clr_ack <= (txn == TXN_CLR);
          state       <= ACK;
        end
        ACK: begin
          bus.ack_a   <= 1'b0;
          bus.ack_b   <= 1'b0;
          bus.clr_ack <= 1'b0;
          bus.busy    <= 1'b0;
          if (txn == TXN_A) begin
            last_b <= 1'b0;
          end else if (txn == TXN_B) begin
            last_b <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Self-checking bench for reg_bank_write_arbiter with a latch-bank model and an ack-order scoreboard.
module tb_reg_bank_write_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_bank_write_arbiter_if bus();
  reg_bank_write_arbiter #(.LOAD_CYCLES(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int         kind;   // 0 = A, 1 = B, 2 = clear
    logic [1:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Behavioural model of the level-sensitive latch bank.
  logic [7:0] bank [4];
  always @(bus.le or bus.wd or bus.wrst) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.wrst) bank[i] = 8'h00;
      else if (bus.le[i]) bank[i] = bus.wd;
    end
  end

  // Scoreboard monitor: records what the enable window looked like and checks it at each ack.
  logic [3:0] prev_le, cap_le;
  logic [7:0] prev_wd, cap_wd;
  logic       cap_wrst;
  int         load_n;
  always @(negedge clk) begin
    exp_t       e;
    int         acks;
    int         got;
    logic [3:0] exp_le;
    if (rst) begin
      load_n = 0; prev_le = 4'd0; prev_wd = 8'd0;
      cap_le = 4'd0; cap_wd = 8'd0; cap_wrst = 1'b0;
    end else begin
      if (bus.le != 4'd0 && prev_le == 4'd0) begin
        n_cmp++;
        if (bus.wd !== prev_wd) begin
          n_err++;
          $display("FAIL le_rise_wd_stable: wd=%h prev=%h", bus.wd, prev_wd);
        end
      end
      if (bus.le != 4'd0) begin
        load_n++;
        cap_le = bus.le; cap_wd = bus.wd; cap_wrst = bus.wrst;
      end
      acks = $countones({bus.ack_a, bus.ack_b, bus.clr_ack});
      if (acks != 0) begin
        n_cmp++;
        if (acks != 1) begin
          n_err++;
          $display("FAIL ack_onehot: acks=%b required one", {bus.ack_a, bus.ack_b, bus.clr_ack});
        end
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sb_unexpected_ack: acks=%b required none", {bus.ack_a, bus.ack_b, bus.clr_ack});
        end else begin
          e   = sb.pop_front();
          got = bus.clr_ack ? 2 : (bus.ack_b ? 1 : 0);
          n_cmp++;
          if (got != e.kind) begin
            n_err++;
            $display("FAIL sb_ack_order: got kind %0d required %0d", got, e.kind);
          end
          exp_le = (e.kind == 2) ? 4'b1111 : (4'b0001 << e.addr);
          n_cmp++;
          if (cap_le !== exp_le || cap_wrst !== (e.kind == 2) || load_n != 3 ||
              (e.kind != 2 && cap_wd !== e.data)) begin
            n_err++;
            $display("FAIL sb_txn: le=%b wrst=%b wd=%h cycles=%0d required le=%b wrst=%b wd=%h cycles=3",
                     cap_le, cap_wrst, cap_wd, load_n, exp_le, (e.kind == 2), e.data);
          end
        end
        load_n = 0;
      end
      prev_le = bus.le; prev_wd = bus.wd;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic get_ack(input int kind);
    case (kind)
      0:       return bus.ack_a;
      1:       return bus.ack_b;
      default: return bus.clr_ack;
    endcase
  endfunction

  task automatic wait_ack(input int kind, input bit drop);
    bit seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (get_ack(kind) === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL ack_timeout: kind %0d not acked within 40 cycles", kind);
    end
    if (drop) begin
      case (kind)
        0:       bus.req_a = 1'b0;
        1:       bus.req_b = 1'b0;
        default: bus.clr_req = 1'b0;
      endcase
    end
  endtask

  task automatic check_reg(input int idx, input logic [7:0] exp);
    n_cmp++;
    if (bank[idx] !== exp) begin
      n_err++;
      $display("FAIL reg%0d: got %h required %h", idx, bank[idx], exp);
    end
  endtask

  task automatic test_reset();
    bus.req_a = 0; bus.addr_a = 0; bus.data_a = 0;
    bus.req_b = 0; bus.addr_b = 0; bus.data_b = 0;
    bus.clr_req = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.le, bus.wd, bus.wrst, bus.busy, bus.ack_a, bus.ack_b, bus.clr_ack} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_outputs: le=%b wd=%h wrst=%b busy=%b acks=%b required all zero",
               bus.le, bus.wd, bus.wrst, bus.busy, {bus.ack_a, bus.ack_b, bus.clr_ack});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_busy: got %b required 0", bus.busy);
    end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    sb.push_back('{kind: 0, addr: 2'd2, data: 8'hA5});
    bus.addr_a = 2'd2; bus.data_a = 8'hA5; bus.req_a = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (n <= 5) begin
        n_cmp++;
        if (bus.wd !== 8'hA5) begin
          n_err++;
          $display("FAIL single_wd c%0d: got %h required a5", n, bus.wd);
        end
      end
      n_cmp++;
      if (bus.le !== ((n >= 2 && n <= 4) ? 4'b0100 : 4'b0000)) begin
        n_err++;
        $display("FAIL single_le c%0d: got %b", n, bus.le);
      end
      n_cmp++;
      if (bus.ack_a !== (n == 6)) begin
        n_err++;
        $display("FAIL single_ack c%0d: got %b required %b", n, bus.ack_a, (n == 6));
      end
      n_cmp++;
      if (bus.busy !== (n <= 6)) begin
        n_err++;
        $display("FAIL single_busy c%0d: got %b required %b", n, bus.busy, (n <= 6));
      end
      if (n == 6) bus.req_a = 1'b0;
    end
    check_reg(2, 8'hA5);
  endtask

  task automatic test_simultaneous();
    rst = 1'b1;
    bus.addr_a = 2'd0; bus.data_a = 8'h11; bus.req_a = 1'b1;
    bus.addr_b = 2'd3; bus.data_b = 8'h22; bus.req_b = 1'b1;
    sb.push_back('{kind: 0, addr: 2'd0, data: 8'h11});
    sb.push_back('{kind: 1, addr: 2'd3, data: 8'h22});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ack(0, 1'b1);
    wait_ack(1, 1'b1);
    @(negedge clk);
    bus.addr_a = 2'd1; bus.data_a = 8'h33; bus.req_a = 1'b1;
    bus.addr_b = 2'd2; bus.data_b = 8'h44; bus.req_b = 1'b1;
    sb.push_back('{kind: 0, addr: 2'd1, data: 8'h33});
    sb.push_back('{kind: 1, addr: 2'd2, data: 8'h44});
    wait_ack(0, 1'b1);
    wait_ack(1, 1'b1);
    check_reg(0, 8'h11);
    check_reg(3, 8'h22);
    check_reg(1, 8'h33);
    check_reg(2, 8'h44);
  endtask

  task automatic test_clear_priority();
    @(negedge clk);
    bus.addr_a = 2'd1; bus.data_a = 8'h77; bus.req_a = 1'b1;
    bus.clr_req = 1'b1;
    sb.push_back('{kind: 2, addr: 2'd0, data: 8'h00});
    sb.push_back('{kind: 0, addr: 2'd1, data: 8'h77});
    wait_ack(2, 1'b1);
    wait_ack(0, 1'b1);
    check_reg(0, 8'h00);
    check_reg(1, 8'h77);
    check_reg(2, 8'h00);
    check_reg(3, 8'h00);
  endtask

  task automatic test_input_change();
    @(negedge clk);
    bus.addr_a = 2'd3; bus.data_a = 8'h5A; bus.req_a = 1'b1;
    sb.push_back('{kind: 0, addr: 2'd3, data: 8'h5A});
    repeat (3) @(negedge clk);
    bus.data_a = 8'hFF;
    bus.addr_a = 2'd0;
    @(negedge clk);
    n_cmp++;
    if (bus.wd !== 8'h5A || bus.le !== 4'b1000) begin
      n_err++;
      $display("FAIL input_change: wd=%h le=%b required wd=5a le=1000", bus.wd, bus.le);
    end
    wait_ack(0, 1'b1);
    check_reg(3, 8'h5A);
  endtask

  task automatic test_reset_in_load();
    @(negedge clk);
    bus.addr_b = 2'd0; bus.data_b = 8'h3C; bus.req_b = 1'b1;
    sb.push_back('{kind: 1, addr: 2'd0, data: 8'h3C});
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.le !== 4'b0001) begin
      n_err++;
      $display("FAIL rst_load_pre: le=%b required 0001", bus.le);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.le !== 4'd0 || bus.wd !== 8'd0 || bus.busy !== 1'b0 || bus.ack_b !== 1'b0) begin
      n_err++;
      $display("FAIL rst_load_drop: le=%b wd=%h busy=%b ack_b=%b required all zero",
               bus.le, bus.wd, bus.busy, bus.ack_b);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ack(1, 1'b1);
    check_reg(0, 8'h3C);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.addr_a = 2'd2; bus.data_a = 8'h9C; bus.req_a = 1'b1;
    sb.push_back('{kind: 0, addr: 2'd2, data: 8'h9C});
    repeat (2) @(negedge clk);
    bus.addr_b = 2'd1; bus.data_b = 8'hB1; bus.req_b = 1'b1;
    sb.push_back('{kind: 1, addr: 2'd1, data: 8'hB1});
    sb.push_back('{kind: 0, addr: 2'd2, data: 8'h9C});
    wait_ack(0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle_gap: busy=%b required 0", bus.busy);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_regrant: busy=%b required 1", bus.busy);
    end
    wait_ack(1, 1'b1);
    wait_ack(0, 1'b1);
    check_reg(1, 8'hB1);
    check_reg(2, 8'h9C);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_simultaneous();
    test_clear_priority();
    test_input_change();
    test_reset_in_load();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d entries left required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_bank_write_arbiter.md
# reg_bank_write_arbiter

Controller that shares a bank of four 8-bit latch-based registers (D latch with reset, level-sensitive enable) between two write requesters and one clear requester. It serialises accesses, drives a stable write-data bus, and generates per-register latch enables and a bank reset. The enables are held long enough for the slow latch to settle. It sits between the requesting datapath blocks and the register bank, and it is the only agent that drives the bank's enable, data and reset lines.

## Interface
- LOAD_CYCLES, 3: cycles a latch enable stays high; must be ≥1 and must cover worst-case latch delay (21 ns) at the system clock period.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_a  in  1  write request from requester A; level, held until ack_a.
- addr_a  in  2  target register index for A.
- data_a  in  8  write data for A.
- ack_a  out  1  one-cycle completion pulse for A.
- req_b, addr_b, data_b, ack_b: same as the A signals, for requester B.
- clr_req  in  1  request to clear all four registers; level, held until clr_ack.
- clr_ack  out  1  one-cycle completion pulse for clear.
- le  out  4  per-register latch enable (drives the register CLK inputs).
- wd  out  8  write data to all registers.
- wrst  out  1  bank reset (drives the register RST inputs).
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SETUP, LOAD, HOLD, ACK.
- IDLE: arbitrate at each rising edge.
  - Priority: clr_req beats req_a and req_b.
  - Between A and B: round-robin. The winner is whichever was not granted last; the last-grant pointer resets to B, so A wins the first tie.
  - A single requester wins immediately.
  - On a grant, capture the winner's addr and data (or the clear flag) into internal registers and go to SETUP.
  - The captured values drive wd and the le index for the whole transaction. Later input changes are ignored.
- SETUP: 1 cycle. wd is driven, le=0, wrst=0.
- LOAD: LOAD_CYCLES cycles, counted by a down-counter.
  - Write transaction: le has one-hot bit [addr] set; wrst=0.
  - Clear transaction: le=4'b1111, wrst=1.
- HOLD: 1 cycle. le=0. wd and wrst keep their LOAD values, giving hold time after the enable falls.
- ACK: 1 cycle. Pulse the matching ack (ack_a, ack_b or clr_ack). wrst=0. Update the last-grant pointer for A/B grants only; clear grants leave it unchanged. Go to IDLE.
- Requester contract: deassert req on the edge that ends the ACK cycle. A req still high in IDLE after that is a new request.
- Only one ack is ever high in a given cycle, and only in ACK.
- Reset values: state=IDLE, le=0, wd=0, wrst=0, busy=0, all acks=0, counter=0, last-grant=B.
- Reset mid-transaction: all outputs go to their reset values asynchronously. The in-flight request gets no ack. The requester keeps req high and is re-arbitrated after RST falls.

## Timing
- Latency: request sampled at edge E0 → SETUP in cycle 1 → LOAD in cycles 2..LOAD_CYCLES+1 → HOLD → ack high in cycle LOAD_CYCLES+3 (cycle 6 for the default of 3).
- Throughput: one transaction per LOAD_CYCLES+4 cycles, including the IDLE arbitration cycle.
- All outputs are registered and glitch-free.
- le never rises in the same cycle that wd changes; wd is stable from SETUP through HOLD.
- A request arriving during busy waits and is served in arbitration order at the next IDLE.
- The LOAD counter never wraps: loaded with LOAD_CYCLES-1 on SETUP exit, and LOAD exits when it reaches 0. For LOAD_CYCLES=1, LOAD lasts exactly one cycle.

## Test plan
- Single write: req_a, addr_a=2, data_a=0xA5, LOAD_CYCLES=3 → wd=0xA5 from cycle 1 to 5; le=4'b0100 in cycles 2–4; ack_a high in cycle 6 only; register 2 reads 0xA5.
- Simultaneous A and B: A writes addr 0 ← 0x11, B writes addr 3 ← 0x22, both held from reset → A served first, then B. Next simultaneous pair → A again, since last grant was B. Registers end at 0x11 and 0x22.
- Clear priority: req_a and clr_req raised together after registers are loaded → le=4'b1111 with wrst=1 for 3 cycles, clr_ack pulses, then A's write proceeds. Final state: all registers 0x00 except A's target.
- Input change mid-transaction: data_a changes 0x5A→0xFF during LOAD → wd stays 0x5A, and the register gets 0x5A.
- Reset in LOAD: assert RST in cycle 3 of a B write → le, wd, busy drop to 0 immediately with no ack_b. After RST is released with req_b still high, the write completes normally.
- Back-to-back: A holds req across its ack, then re-raises it while B waits → B granted next (round-robin); no ack overlap; busy stays low for exactly one IDLE cycle between transactions.
